// File: rtl/clint_pkg.sv
// Shared constants for the core-local interrupt/trap controller: CSR addresses,
// system instruction encodings, trap causes and the sequencer state type.
package clint_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;

  typedef enum logic [2:0] {
    StIdle,
    StMepc,
    StMcause,
    StMstatus,
    StMret,
    StJump
  } clint_state_e;

endpackage

// File: rtl/clint.sv
// Trap/interrupt sequencer: detects ecall/ebreak/mret/irq in execute, stalls the
// pipeline, writes mepc/mcause/mstatus through the CSR clint port, then redirects the PC.
module clint #(
  parameter logic [31:0] INT_CAUSE = 32'h8000_000B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        irq_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic [31:0] csr_mie_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        stall_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);
  import clint_pkg::*;

  clint_state_e state_q;
  logic [31:0]  cause_q;
  logic [31:0]  pc_q;
  logic         mret_q;

  logic is_ecall, is_ebreak, is_mret, is_irq, any_event;

  assign is_ecall  = inst_valid_i && (inst_i == INST_ECALL);
  assign is_ebreak = inst_valid_i && (inst_i == INST_EBREAK);
  assign is_mret   = inst_valid_i && (inst_i == INST_MRET);
  assign is_irq    = inst_valid_i && irq_i && csr_mstatus_i[3] && csr_mie_i[11];
  assign any_event = is_ecall || is_ebreak || is_mret || is_irq;

  logic unused_bits;
  assign unused_bits = ^{csr_mie_i[31:12], csr_mie_i[10:0], csr_mtvec_i[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cause_q <= 32'h0;
      pc_q    <= 32'h0;
      mret_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_ecall) begin
            cause_q <= CAUSE_ECALL;
            pc_q    <= inst_addr_i;
            mret_q  <= 1'b0;
            state_q <= StMepc;
          end else if (is_ebreak) begin
            cause_q <= CAUSE_EBREAK;
            pc_q    <= inst_addr_i;
            mret_q  <= 1'b0;
            state_q <= StMepc;
          end else if (is_mret) begin
            mret_q  <= 1'b1;
            state_q <= StMret;
          end else if (is_irq) begin
            cause_q <= INT_CAUSE;
            pc_q    <= inst_addr_i;
            mret_q  <= 1'b0;
            state_q <= StMepc;
          end
        end
        StMepc:    state_q <= StMcause;
        StMcause:  state_q <= StMstatus;
        StMstatus: state_q <= StJump;
        StMret:    state_q <= StJump;
        StJump:    state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    csr_we_o     = 1'b0;
    csr_waddr_o  = 32'h0;
    csr_wdata_o  = 32'h0;
    stall_o      = 1'b1;
    int_assert_o = 1'b0;
    int_addr_o   = 32'h0;
    unique case (state_q)
      StIdle: stall_o = any_event;
      StMepc: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'h0, CSR_MEPC};
        csr_wdata_o = pc_q;
      end
      StMcause: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'h0, CSR_MCAUSE};
        csr_wdata_o = cause_q;
      end
      StMstatus: begin
        // Save MIE into MPIE and disable interrupts.
        csr_we_o       = 1'b1;
        csr_waddr_o    = {20'h0, CSR_MSTATUS};
        csr_wdata_o    = csr_mstatus_i;
        csr_wdata_o[7] = csr_mstatus_i[3];
        csr_wdata_o[3] = 1'b0;
      end
      StMret: begin
        // Restore MIE from MPIE and set MPIE.
        csr_we_o       = 1'b1;
        csr_waddr_o    = {20'h0, CSR_MSTATUS};
        csr_wdata_o    = csr_mstatus_i;
        csr_wdata_o[3] = csr_mstatus_i[7];
        csr_wdata_o[7] = 1'b1;
      end
      StJump: begin
        int_assert_o = 1'b1;
        int_addr_o   = mret_q ? csr_mepc_i : {csr_mtvec_i[31:2], 2'b00};
      end
      default: stall_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: one linear sequence of trap, interrupt, mret and reset scenarios.
module tb_clint;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid_i;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        irq_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;
  logic [31:0] csr_mie_i;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        stall_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  always #5 clk = ~clk;

  clint dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_valid_i (inst_valid_i),
    .inst_i       (inst_i),
    .inst_addr_i  (inst_addr_i),
    .irq_i        (irq_i),
    .csr_mtvec_i  (csr_mtvec_i),
    .csr_mepc_i   (csr_mepc_i),
    .csr_mstatus_i(csr_mstatus_i),
    .csr_mie_i    (csr_mie_i),
    .csr_we_o     (csr_we_o),
    .csr_waddr_o  (csr_waddr_o),
    .csr_wdata_o  (csr_wdata_o),
    .stall_o      (stall_o),
    .int_assert_o (int_assert_o),
    .int_addr_o   (int_addr_o)
  );

  // Compare all outputs at once against the expected tuple.
  task automatic cmp(input string tag, input logic we, input logic [31:0] wa,
                     input logic [31:0] wd, input logic st, input logic ia,
                     input logic [31:0] iaddr);
    logic [98:0] obs, exp;
    obs = {csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, int_assert_o, int_addr_o};
    exp = {we, wa, wd, st, ia, iaddr};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed we=%b wa=%h wd=%h st=%b ia=%b ta=%h expected we=%b wa=%h wd=%h st=%b ia=%b ta=%h",
             tag, obs[98], obs[97:66], obs[65:34], obs[33], obs[32], obs[31:0],
             we, wa, wd, st, ia, iaddr);
    end
  endtask

  // Check at the falling edge, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic we, input logic [31:0] wa,
                      input logic [31:0] wd, input logic st, input logic ia,
                      input logic [31:0] iaddr);
    @(negedge clk);
    cmp(tag, we, wa, wd, st, ia, iaddr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    inst_valid_i  = 1'b0;
    inst_i        = NOP;
    inst_addr_i   = 32'h0;
    irq_i         = 1'b0;
    csr_mtvec_i   = 32'h200;
    csr_mepc_i    = 32'h0;
    csr_mstatus_i = 32'h8;
    csr_mie_i     = 32'h0;

    step("reset", 0, 0, 0, 0, 0, 0);
    step("reset2", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step("idle", 0, 0, 0, 0, 0, 0);

    // ECALL at 0x100, MIE=1.
    inst_valid_i = 1'b1; inst_i = ECALL; inst_addr_i = 32'h100;
    step("ecall_detect", 0, 0, 0, 1, 0, 0);
    step("ecall_mepc", 1, 32'h341, 32'h100, 1, 0, 0);
    step("ecall_mcause", 1, 32'h342, 32'd11, 1, 0, 0);
    step("ecall_mstatus", 1, 32'h300, 32'h80, 1, 0, 0);
    step("ecall_jump", 0, 0, 0, 1, 1, 32'h200);
    inst_valid_i = 1'b0;
    step("ecall_done", 0, 0, 0, 0, 0, 0);

    // External interrupt at 0x40.
    csr_mstatus_i = 32'h8; csr_mie_i = 32'h800; irq_i = 1'b1;
    inst_valid_i = 1'b1; inst_i = NOP; inst_addr_i = 32'h40;
    step("irq_detect", 0, 0, 0, 1, 0, 0);
    step("irq_mepc", 1, 32'h341, 32'h40, 1, 0, 0);
    step("irq_mcause", 1, 32'h342, 32'h8000_000B, 1, 0, 0);
    step("irq_mstatus", 1, 32'h300, 32'h80, 1, 0, 0);
    step("irq_jump", 0, 0, 0, 1, 1, 32'h200);
    csr_mstatus_i = 32'h0;
    step("irq_masked", 0, 0, 0, 0, 0, 0);
    step("irq_masked2", 0, 0, 0, 0, 0, 0);
    irq_i = 1'b0;

    // MRET back to 0x104.
    csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
    inst_i = MRET; inst_addr_i = 32'h300;
    step("mret_detect", 0, 0, 0, 1, 0, 0);
    step("mret_mstatus", 1, 32'h300, 32'h88, 1, 0, 0);
    step("mret_jump", 0, 0, 0, 1, 1, 32'h104);
    inst_valid_i = 1'b0;
    step("mret_done", 0, 0, 0, 0, 0, 0);

    // ECALL and IRQ together: ECALL wins; IRQ waits for MIE to come back.
    csr_mstatus_i = 32'h8; irq_i = 1'b1;
    inst_valid_i = 1'b1; inst_i = ECALL; inst_addr_i = 32'h120;
    step("both_detect", 0, 0, 0, 1, 0, 0);
    step("both_mepc", 1, 32'h341, 32'h120, 1, 0, 0);
    step("both_mcause", 1, 32'h342, 32'd11, 1, 0, 0);
    step("both_mstatus", 1, 32'h300, 32'h80, 1, 0, 0);
    csr_mstatus_i = 32'h80;
    step("both_jump", 0, 0, 0, 1, 1, 32'h200);
    inst_i = NOP; inst_addr_i = 32'h124;
    step("both_irq_held", 0, 0, 0, 0, 0, 0);
    csr_mstatus_i = 32'h88;
    step("late_irq_detect", 0, 0, 0, 1, 0, 0);
    step("late_irq_mepc", 1, 32'h341, 32'h124, 1, 0, 0);
    step("late_irq_mcause", 1, 32'h342, 32'h8000_000B, 1, 0, 0);
    step("late_irq_mstatus", 1, 32'h300, 32'h80, 1, 0, 0);
    step("late_irq_jump", 0, 0, 0, 1, 1, 32'h200);
    inst_valid_i = 1'b0; irq_i = 1'b0;
    step("late_irq_done", 0, 0, 0, 0, 0, 0);

    // EBREAK with misaligned mtvec and MIE=0.
    csr_mtvec_i = 32'h203; csr_mstatus_i = 32'h0;
    inst_valid_i = 1'b1; inst_i = EBREAK; inst_addr_i = 32'h50;
    step("ebreak_detect", 0, 0, 0, 1, 0, 0);
    step("ebreak_mepc", 1, 32'h341, 32'h50, 1, 0, 0);
    step("ebreak_mcause", 1, 32'h342, 32'd3, 1, 0, 0);
    step("ebreak_mstatus", 1, 32'h300, 32'h0, 1, 0, 0);
    step("ebreak_jump", 0, 0, 0, 1, 1, 32'h200);
    inst_valid_i = 1'b0;
    step("ebreak_done", 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a trap sequence.
    inst_valid_i = 1'b1; inst_i = ECALL; inst_addr_i = 32'h60;
    step("rst_detect", 0, 0, 0, 1, 0, 0);
    step("rst_mepc", 1, 32'h341, 32'h60, 1, 0, 0);
    @(negedge clk);
    cmp("rst_mcause", 1, 32'h342, 32'd11, 1, 0, 0);
    #2;
    inst_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    cmp("rst_async", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rst_idle", 0, 0, 0, 0, 0, 0);
    inst_valid_i = 1'b1; inst_i = ECALL; inst_addr_i = 32'h70;
    step("post_rst_detect", 0, 0, 0, 1, 0, 0);
    step("post_rst_mepc", 1, 32'h341, 32'h70, 1, 0, 0);
    step("post_rst_mcause", 1, 32'h342, 32'd11, 1, 0, 0);
    step("post_rst_mstatus", 1, 32'h300, 32'h0, 1, 0, 0);
    step("post_rst_jump", 0, 0, 0, 1, 1, 32'h200);
    inst_valid_i = 1'b0;
    step("post_rst_done", 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
